vga_timing_pattern_gen: RTL and testbench

- Parametrised successor to the fixed 640x480 video sync generator.
- Generates VGA timing for any resolution, with programmable sync polarity and an internal pixel-rate prescaler, so it can run from CLOCK_50 directly without a derived clock.
- Emits pixel coordinates, line/frame strobes and a built-in test-pattern RGB stream aligned to blank_n.
- Sits between the board top level and the VGA DAC pins.

---
 rtl/vga_pkg.sv | 37 +++
 rtl/vga_pattern_gen.sv | 67 ++++++
 rtl/vga_timing_pattern_gen.sv | 129 ++++++++++++
 tb/tb_vga_timing_pattern_gen.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared encodings and default timing for the VGA timing / test-pattern generator.
// Defaults describe 640x480@60 with a 25 MHz pixel rate.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_GRID  = 2'd2,
        MODE_CHECK = 2'd3
    } vga_mode_e;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    // Colour-bar table, one bit per channel {R,G,B}, left to right.
    function automatic logic [2:0] bar_colour(input logic [2:0] idx);
        logic [2:0] c;
        case (idx)
            3'd0:    c = 3'b111;
            3'd1:    c = 3'b110;
            3'd2:    c = 3'b011;
            3'd3:    c = 3'b010;
            3'd4:    c = 3'b101;
            3'd5:    c = 3'b100;
            3'd6:    c = 3'b001;
            default: c = 3'b000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_pattern_gen.sv
// Test-pattern colour generator. Output is combinational for the current counter
// position; the parent registers it alongside the sync signals.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int XW       = 10,
    parameter int YW       = 10,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int CW       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              line_start,
    input  logic [XW-1:0]     x,
    input  logic [YW-1:0]     y,
    input  logic [1:0]        mode,
    input  logic [3*CW-1:0]   solid_rgb,
    output logic [3*CW-1:0]   rgb
);

    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam int BW    = $clog2(BAR_W + 1);

    logic [BW-1:0] bar_cnt_q, bar_cnt;
    logic [2:0]    bar_idx_q, bar_idx;
    logic [2:0]    bar_c;
    logic [31:0]   xe, ye;

    // At h==0 the bar position restarts regardless of what the registers hold.
    always_comb begin
        bar_cnt = line_start ? '0 : bar_cnt_q;
        bar_idx = line_start ? '0 : bar_idx_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
        end else if (tick) begin
            if (bar_cnt == BW'(BAR_W - 1)) begin
                bar_cnt_q <= '0;
                bar_idx_q <= (bar_idx == 3'd7) ? 3'd7 : bar_idx + 3'd1;
            end else begin
                bar_cnt_q <= bar_cnt + BW'(1);
                bar_idx_q <= bar_idx;
            end
        end
    end

    always_comb begin
        xe    = 32'(x);
        ye    = 32'(y);
        bar_c = bar_colour(bar_idx);
        rgb   = '0;
        case (mode)
            MODE_SOLID: rgb = solid_rgb;
            MODE_BARS:  rgb = {{CW{bar_c[2]}}, {CW{bar_c[1]}}, {CW{bar_c[0]}}};
            MODE_GRID:  rgb = (xe[4:0] == 5'd0 || ye[4:0] == 5'd0 ||
                               xe == 32'(H_ACTIVE - 1) || ye == 32'(V_ACTIVE - 1))
                              ? {3*CW{1'b1}} : '0;
            default:    rgb = (xe[5] ^ ye[5]) ? {3*CW{1'b1}} : solid_rgb;
        endcase
    end

endmodule

// File: rtl/vga_timing_pattern_gen.sv
// Parametrised VGA sync generator with pixel-rate prescaler and built-in test patterns.
// All outputs come from one registered stage updated on each pixel tick.
module vga_timing_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CLK_DIV  = 1,
    parameter int CW       = 8,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int XW      = $clog2(H_TOTAL),
    localparam int YW      = $clog2(V_TOTAL)
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [3*CW-1:0]   solid_rgb,
    output logic              pix_tick,
    output logic              hs,
    output logic              vs,
    output logic              blank_n,
    output logic [XW-1:0]     x,
    output logic [YW-1:0]     y,
    output logic              line_start,
    output logic              frame_start,
    output logic [CW-1:0]     vga_r,
    output logic [CW-1:0]     vga_g,
    output logic [CW-1:0]     vga_b
);

    localparam int   DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    logic [DW-1:0]     div_cnt;
    logic [XW-1:0]     h;
    logic [YW-1:0]     v;
    logic [1:0]        mode_q, eff_mode;
    logic              tick, at_line, at_frame, hs_d, vs_d, blank_d;
    logic [3*CW-1:0]   rgb_d;

    always_comb begin
        tick     = enable && (div_cnt == DW'(CLK_DIV - 1));
        at_line  = (h == '0);
        at_frame = at_line && (v == '0);
        hs_d     = (h >= XW'(H_ACTIVE + H_FP) && h < XW'(H_ACTIVE + H_FP + H_SYNC))
                   ? HS_ON : ~HS_ON;
        vs_d     = (v >= YW'(V_ACTIVE + V_FP) && v < YW'(V_ACTIVE + V_FP + V_SYNC))
                   ? VS_ON : ~VS_ON;
        blank_d  = (h < XW'(H_ACTIVE)) && (v < YW'(V_ACTIVE));
        // The frame's first pixel already uses the newly sampled mode.
        eff_mode = at_frame ? mode : mode_q;
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            h       <= '0;
            v       <= '0;
            mode_q  <= '0;
        end else if (!enable) begin
            div_cnt <= '0;
            h       <= '0;
            v       <= '0;
            mode_q  <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            if (at_frame) mode_q <= mode;
            if (h == XW'(H_TOTAL - 1)) begin
                h <= '0;
                v <= (v == YW'(V_TOTAL - 1)) ? '0 : v + YW'(1);
            end else begin
                h <= h + XW'(1);
            end
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    vga_pattern_gen #(
        .XW(XW), .YW(YW), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .CW(CW)
    ) u_pattern (
        .clk(vga_clk), .reset(reset), .tick(tick), .line_start(at_line),
        .x(h), .y(v), .mode(eff_mode), .solid_rgb(solid_rgb), .rgb(rgb_d)
    );

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            {pix_tick, blank_n, line_start, frame_start} <= '0;
            hs <= ~HS_ON;
            vs <= ~VS_ON;
            x  <= '0;
            y  <= '0;
            {vga_r, vga_g, vga_b} <= '0;
        end else if (!enable) begin
            {pix_tick, blank_n, line_start, frame_start} <= '0;
            hs <= ~HS_ON;
            vs <= ~VS_ON;
            x  <= '0;
            y  <= '0;
            {vga_r, vga_g, vga_b} <= '0;
        end else if (tick) begin
            pix_tick    <= 1'b1;
            line_start  <= at_line;
            frame_start <= at_frame;
            hs          <= hs_d;
            vs          <= vs_d;
            blank_n     <= blank_d;
            x           <= h;
            y           <= v;
            {vga_r, vga_g, vga_b} <= blank_d ? rgb_d : '0;
        end else begin
            pix_tick    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_pattern_gen.sv
// Bench for vga_timing_pattern_gen: three instances (default, CLK_DIV=2, small
// positive-polarity raster) checked every clock against a pixel-index model.
module tb_vga_timing_pattern_gen;

    typedef struct {
        int ha, hf, hsw, hb, va, vf, vsw, vb, hpol, vpol, div;
    } cfg_t;

    typedef struct packed {
        logic        pt, hs, vs, bl;
        logic [15:0] x, y;
        logic        ls, fs;
        logic [23:0] rgb;
    } ov_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  [3];
    logic [1:0]  md  [3];
    logic [23:0] sol [3];
    logic        pt [3], hs [3], vs [3], bl [3], ls [3], fs [3];
    logic [7:0]  r [3], g [3], b [3];
    logic [9:0]  xa, ya, xb, yb;
    logic [4:0]  xc;
    logic [3:0]  yc;
    ov_t         obs   [3];
    ov_t         exp_v [3];
    int          cnt [3];
    int          lm  [3];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    vga_timing_pattern_gen u_a (
        .vga_clk(clk), .reset(rst), .enable(en[0]), .mode(md[0]), .solid_rgb(sol[0]),
        .pix_tick(pt[0]), .hs(hs[0]), .vs(vs[0]), .blank_n(bl[0]), .x(xa), .y(ya),
        .line_start(ls[0]), .frame_start(fs[0]), .vga_r(r[0]), .vga_g(g[0]), .vga_b(b[0])
    );

    vga_timing_pattern_gen #(.CLK_DIV(2)) u_b (
        .vga_clk(clk), .reset(rst), .enable(en[1]), .mode(md[1]), .solid_rgb(sol[1]),
        .pix_tick(pt[1]), .hs(hs[1]), .vs(vs[1]), .blank_n(bl[1]), .x(xb), .y(yb),
        .line_start(ls[1]), .frame_start(fs[1]), .vga_r(r[1]), .vga_g(g[1]), .vga_b(b[1])
    );

    vga_timing_pattern_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .CLK_DIV(1)
    ) u_c (
        .vga_clk(clk), .reset(rst), .enable(en[2]), .mode(md[2]), .solid_rgb(sol[2]),
        .pix_tick(pt[2]), .hs(hs[2]), .vs(vs[2]), .blank_n(bl[2]), .x(xc), .y(yc),
        .line_start(ls[2]), .frame_start(fs[2]), .vga_r(r[2]), .vga_g(g[2]), .vga_b(b[2])
    );

    assign obs[0] = {pt[0], hs[0], vs[0], bl[0], 16'(xa), 16'(ya), ls[0], fs[0], r[0], g[0], b[0]};
    assign obs[1] = {pt[1], hs[1], vs[1], bl[1], 16'(xb), 16'(yb), ls[1], fs[1], r[1], g[1], b[1]};
    assign obs[2] = {pt[2], hs[2], vs[2], bl[2], 16'(xc), 16'(yc), ls[2], fs[2], r[2], g[2], b[2]};

    // ---------------- reference model ----------------
    function automatic cfg_t get_cfg(input int k);
        cfg_t c;
        if (k == 2) c = '{16, 2, 3, 3, 8, 1, 1, 1, 1, 1, 1};
        else        c = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, (k == 1) ? 2 : 1};
        return c;
    endfunction

    function automatic ov_t reset_vec(input cfg_t c);
        ov_t o;
        o     = '0;
        o.hs  = (c.hpol == 0);
        o.vs  = (c.vpol == 0);
        return o;
    endfunction

    function automatic ov_t decode(input cfg_t c, input int h, input int v, input int m,
                                   input logic [23:0] s);
        ov_t o;
        int  idx;
        logic [23:0] bars [8];
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        o.pt = 1'b1;
        o.hs = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hsw) ? (c.hpol != 0) : (c.hpol == 0);
        o.vs = (v >= c.va + c.vf && v < c.va + c.vf + c.vsw) ? (c.vpol != 0) : (c.vpol == 0);
        o.bl = (h < c.ha) && (v < c.va);
        o.x  = 16'(h);
        o.y  = 16'(v);
        o.ls = (h == 0);
        o.fs = (h == 0) && (v == 0);
        idx  = h / (c.ha / 8);
        if (idx > 7) idx = 7;
        if (!o.bl) o.rgb = 24'h0;
        else begin
            case (m)
                0: o.rgb = s;
                1: o.rgb = bars[idx];
                2: o.rgb = ((h % 32) == 0 || (v % 32) == 0 || h == c.ha - 1 || v == c.va - 1)
                           ? 24'hFFFFFF : 24'h0;
                default: o.rgb = (((h / 32) % 2) != ((v / 32) % 2)) ? 24'hFFFFFF : s;
            endcase
        end
        return o;
    endfunction

    // Counts enabled clocks since start; pixel index = completed ticks - 1.
    always @(posedge clk or posedge rst) begin : model
        cfg_t c;
        int   ht, vt, p;
        for (int k = 0; k < 3; k++) begin
            c  = get_cfg(k);
            ht = c.ha + c.hf + c.hsw + c.hb;
            vt = c.va + c.vf + c.vsw + c.vb;
            if (rst || !en[k]) begin
                cnt[k]   = 0;
                lm[k]    = 0;
                exp_v[k] = reset_vec(c);
            end else begin
                cnt[k]++;
                if (cnt[k] % c.div == 0) begin
                    p = (cnt[k] / c.div - 1) % (ht * vt);
                    if (p == 0) lm[k] = int'(md[k]);
                    exp_v[k] = decode(c, p % ht, p / ht, lm[k], sol[k]);
                end else begin
                    exp_v[k].pt = 1'b0;
                    exp_v[k].ls = 1'b0;
                    exp_v[k].fs = 1'b0;
                end
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== reset_vec(get_cfg(k))) begin
                errors++;
                $display("FAIL reset_state dut%0d: got %h want %h", k, obs[k], reset_vec(get_cfg(k)));
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_default_line();
        int hs_low = 0, first_hs = -1, bl_cnt = 0;
        int ls_t [$];
        en[0] = 1'b1; md[0] = 2'd0; sol[0] = 24'h4080C0;
        for (int i = 0; i < 1700; i++) begin
            @(negedge clk);
            checks++;
            if (obs[0] !== exp_v[0]) begin
                errors++;
                if (errors < 30) $display("FAIL default_line cyc %0d: got %h want %h", i, obs[0], exp_v[0]);
            end
            if (obs[0].y == 0 && !obs[0].hs) begin
                hs_low++;
                if (first_hs < 0) first_hs = int'(obs[0].x);
            end
            if (obs[0].y == 0 && obs[0].bl) bl_cnt++;
            if (obs[0].ls) ls_t.push_back(i);
        end
        checks++;
        if (hs_low != 96) begin errors++; $display("FAIL hs_low_width: got %0d want 96", hs_low); end
        checks++;
        if (first_hs != 656) begin errors++; $display("FAIL hs_start_x: got %0d want 656", first_hs); end
        checks++;
        if (bl_cnt != 640) begin errors++; $display("FAIL blank_width: got %0d want 640", bl_cnt); end
        checks++;
        if (ls_t.size() < 2 || ls_t[1] - ls_t[0] != 800) begin
            errors++;
            $display("FAIL line_period: got %0d starts, want period 800", ls_t.size());
        end
        en[0] = 1'b0;
    endtask

    task automatic test_clk_div2();
        int ticks = 0, hs_low = 0;
        int ls_t [$];
        en[1] = 1'b1; md[1] = 2'd0; sol[1] = 24'($urandom);
        for (int i = 0; i < 3300; i++) begin
            @(negedge clk);
            checks++;
            if (obs[1] !== exp_v[1]) begin
                errors++;
                if (errors < 30) $display("FAIL clk_div2 cyc %0d: got %h want %h", i, obs[1], exp_v[1]);
            end
            if (i < 1600 && obs[1].pt) ticks++;
            if (obs[1].y == 0 && !obs[1].hs) hs_low++;
            if (obs[1].ls) ls_t.push_back(i);
        end
        checks++;
        if (ticks != 800) begin errors++; $display("FAIL div2_ticks: got %0d want 800", ticks); end
        checks++;
        if (hs_low != 192) begin errors++; $display("FAIL div2_hs_clocks: got %0d want 192", hs_low); end
        checks++;
        if (ls_t.size() < 2 || ls_t[1] - ls_t[0] != 1600) begin
            errors++;
            $display("FAIL div2_line_period: got %0d starts, want period 1600", ls_t.size());
        end
        en[1] = 1'b0;
    endtask

    task automatic test_bars();
        logic [23:0] col [16];
        logic [23:0] want [8];
        int hs_hi = 0, first_hs = -1;
        want = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        for (int i = 0; i < 16; i++) col[i] = 24'hDEAD00;
        en[2] = 1'b1; md[2] = 2'd1; sol[2] = 24'($urandom);
        for (int i = 0; i < 528; i++) begin
            @(negedge clk);
            checks++;
            if (obs[2] !== exp_v[2]) begin
                errors++;
                if (errors < 30) $display("FAIL bars cyc %0d: got %h want %h", i, obs[2], exp_v[2]);
            end
            if (i < 24 && obs[2].y == 0 && obs[2].pt) begin
                if (obs[2].x < 16) col[obs[2].x] = obs[2].rgb;
                if (obs[2].hs) begin
                    hs_hi++;
                    if (first_hs < 0) first_hs = int'(obs[2].x);
                end
            end
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (col[i] !== want[i / 2]) begin
                errors++;
                $display("FAIL bar_colour x=%0d: got %h want %h", i, col[i], want[i / 2]);
            end
        end
        checks++;
        if (hs_hi != 3 || first_hs != 18) begin
            errors++;
            $display("FAIL small_hs: got %0d wide at %0d want 3 wide at 18", hs_hi, first_hs);
        end
    endtask

    task automatic test_mode_change();
        bit found = 0, changed = 0, seen_old = 0, seen_new = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            checks++;
            if (obs[2] !== exp_v[2]) begin
                errors++;
                if (errors < 30) $display("FAIL mode_wait cyc %0d: got %h want %h", i, obs[2], exp_v[2]);
            end
            if (obs[2].y == 4 && obs[2].x == 0) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL mode_wait_timeout: got no y=4 want y=4"); end
        md[2] = 2'd2;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            checks++;
            if (obs[2] !== exp_v[2]) begin
                errors++;
                if (errors < 30) $display("FAIL mode_change cyc %0d: got %h want %h", i, obs[2], exp_v[2]);
            end
            if (obs[2].fs) changed = 1;
            if (!changed && !seen_old && obs[2].pt && obs[2].x == 2 && obs[2].y == 4) begin
                seen_old = 1;
                checks++;
                if (obs[2].rgb !== 24'hFFFF00) begin
                    errors++;
                    $display("FAIL bars_before_frame: got %h want FFFF00", obs[2].rgb);
                end
            end
            if (changed && !seen_new) begin
                seen_new = 1;
                checks++;
                if (obs[2].rgb !== 24'hFFFFFF) begin
                    errors++;
                    $display("FAIL grid_first_pixel: got %h want FFFFFF", obs[2].rgb);
                end
            end
        end
    endtask

    task automatic test_enable_drop();
        bit found = 0, got_tick = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            checks++;
            if (obs[2] !== exp_v[2]) begin
                errors++;
                if (errors < 30) $display("FAIL en_wait cyc %0d: got %h want %h", i, obs[2], exp_v[2]);
            end
            if (obs[2].x == 10 && obs[2].y == 5) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL en_wait_timeout: got none want x=10 y=5"); end
        en[2] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (obs[2] !== reset_vec(get_cfg(2))) begin
                errors++;
                $display("FAIL enable_idle cyc %0d: got %h want %h", i, obs[2], reset_vec(get_cfg(2)));
            end
        end
        en[2] = 1'b1;
        for (int i = 0; i < 5 && !got_tick; i++) begin
            @(negedge clk);
            if (obs[2].pt) begin
                got_tick = 1;
                checks++;
                if (obs[2].x != 0 || obs[2].y != 0 || !obs[2].fs) begin
                    errors++;
                    $display("FAIL reenable_first: got x=%0d y=%0d fs=%0d want 0 0 1",
                             obs[2].x, obs[2].y, obs[2].fs);
                end
            end
        end
        checks++;
        if (!got_tick) begin errors++; $display("FAIL reenable_timeout: got no tick want tick"); end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if (obs[2] !== exp_v[2]) begin
                errors++;
                if (errors < 30) $display("FAIL after_reenable cyc %0d: got %h want %h", i, obs[2], exp_v[2]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (obs[2].x == 7 && obs[2].y != 0) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL rst_wait_timeout: got none want x=7"); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs[2] !== reset_vec(get_cfg(2))) begin
            errors++;
            $display("FAIL async_reset: got %h want %h", obs[2], reset_vec(get_cfg(2)));
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (!obs[2].pt || obs[2].x != 0 || obs[2].y != 0 || !obs[2].fs) begin
            errors++;
            $display("FAIL restart_after_reset: got %h want tick at x=0 y=0 fs=1", obs[2]);
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            checks++;
            if (obs[2] !== exp_v[2]) begin
                errors++;
                if (errors < 30) $display("FAIL after_reset cyc %0d: got %h want %h", i, obs[2], exp_v[2]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            checks++;
            if (obs[2] !== exp_v[2]) begin
                errors++;
                if (errors < 30) $display("FAIL random cyc %0d: got %h want %h", i, obs[2], exp_v[2]);
            end
            if ($urandom_range(0, 49) == 0) md[2] = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) sol[2] = 24'($urandom);
            if (!en[2]) en[2] = ($urandom_range(0, 2) == 0);
            else if ($urandom_range(0, 199) == 0) en[2] = 1'b0;
        end
        en[2] = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            en[k] = 1'b0; md[k] = 2'd0; sol[k] = 24'h0;
        end
        test_reset();
        test_default_line();
        test_clk_div2();
        test_bars();
        test_mode_change();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
